// File: rtl/clkdom_gen.sv
// Multi-channel divided-clock generator with per-channel domain reset sequencer.
// Optional clock gating is compiled in with CLKDOM_GEN_GATE_EN.
module clkdom_gen #(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = 4,
    parameter int RST_HOLD = 1,
    parameter int DEF_HALF = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*DIV_W-1:0]   half_cnt,
    input  logic [NUM_CH-1:0]         load,
    input  logic [NUM_CH-1:0]         sw_rst,
    input  logic [NUM_CH-1:0]         gate,
    output logic [NUM_CH-1:0]         cd_clk,
    output logic [NUM_CH-1:0]         cd_rise,
    output logic [NUM_CH-1:0]         cd_reset,
    output logic [NUM_CH-1:0]         cd_busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [DIV_W-1:0] DEF_HALF_V = DIV_W'(DEF_HALF);
    localparam logic [3:0]       HOLD_INIT  = 4'(RST_HOLD - 1);

`ifndef CLKDOM_GEN_GATE_EN
    logic [NUM_CH-1:0] gate_unused;
    assign gate_unused = gate;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] act_half;
        logic [DIV_W-1:0] shd_half;
        logic             clk_q;
        logic             rise_q;
        logic             reset_q;
        logic             pending;
        logic [1:0]       state;
        logic [3:0]       hold;
        logic             run;
        logic             term;
        logic             fall_tc;
        logic             pend_now;

`ifdef CLKDOM_GEN_GATE_EN
        logic gated;

        // Gating is only entered on a falling edge so the high phase is never cut short.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                gated <= 1'b0;
            end else if (gated) begin
                if (!gate[i]) begin
                    gated <= 1'b0;
                end
            end else if (fall_tc) begin
                gated <= gate[i];
            end
        end

        assign run = ~gated;
`else
        assign run = 1'b1;
`endif

        assign term     = (cnt == act_half);
        assign fall_tc  = run & term & clk_q;
        assign pend_now = pending | sw_rst[i];

        // Shadow-to-active transfer uses the pre-load shadow, so a same-edge load waits a period.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt      <= '0;
                act_half <= DEF_HALF_V;
                shd_half <= DEF_HALF_V;
                clk_q    <= 1'b0;
                rise_q   <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                if (load[i]) begin
                    shd_half <= half_cnt[i*DIV_W +: DIV_W];
                end
                if (!run) begin
                    cnt   <= '0;
                    clk_q <= 1'b0;
                end else if (term) begin
                    cnt    <= '0;
                    clk_q  <= ~clk_q;
                    rise_q <= ~clk_q;
                    if (clk_q) begin
                        act_half <= shd_half;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        // A request is consumed by the edge that (re)asserts cd_reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pending <= 1'b1;
            end else if (fall_tc && (state == ST_ASSERT || (state == ST_HOLD && pend_now))) begin
                pending <= 1'b0;
            end else if (sw_rst[i]) begin
                pending <= 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state   <= ST_IDLE;
                reset_q <= 1'b0;
                hold    <= '0;
            end else if (fall_tc) begin
                case (state)
                    ST_IDLE: begin
                        if (pend_now) begin
                            state <= ST_ASSERT;
                        end
                    end
                    ST_ASSERT: begin
                        reset_q <= 1'b1;
                        hold    <= HOLD_INIT;
                        state   <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (pend_now) begin
                            reset_q <= 1'b1;
                            hold    <= HOLD_INIT;
                        end else if (hold == 4'd0) begin
                            reset_q <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            hold <= hold - 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        reset_q <= 1'b0;
                    end
                endcase
            end
        end

        assign cd_clk[i]   = clk_q;
        assign cd_rise[i]  = rise_q;
        assign cd_reset[i] = reset_q;
        assign cd_busy[i]  = pending | (state != ST_IDLE);
    end

endmodule

// File: tb/tb_clkdom_gen.sv
// Randomized scoreboard bench for clkdom_gen: two instances (hold 1 and hold 3) share stimulus
// and are compared every cycle against a phase-countdown reference model.
module tb_clkdom_gen;

    localparam int NI    = 2;
    localparam int NC    = 2;
    localparam int DW    = 4;
    localparam int HOLD0 = 1;
    localparam int HOLD1 = 3;
    localparam int DEFH  = 1;
    localparam int EW    = 4 * NC;
`ifdef CLKDOM_GEN_GATE_EN
    localparam bit GATE_EN = 1'b1;
`else
    localparam bit GATE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NC*DW-1:0] half_cnt = '0;
    logic [NC-1:0] load = '0;
    logic [NC-1:0] sw_rst = '0;
    logic [NC-1:0] gate = '0;

    logic [NC-1:0] clk0, rise0, reset0, busy0;
    logic [NC-1:0] clk1, rise1, reset1, busy1;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [NI*EW-1:0] exp_q[$];
    logic [NI*EW-1:0] exp_w;
    logic [NI*EW-1:0] exp_m;

    int m_left [NI][NC];
    int m_act  [NI][NC];
    int m_shd  [NI][NC];
    int m_hl   [NI][NC];
    int m_stage[NI][NC];
    bit m_clk  [NI][NC];
    bit m_rise [NI][NC];
    bit m_rst  [NI][NC];
    bit m_pend [NI][NC];
    bit m_gated[NI][NC];

    clkdom_gen #(.NUM_CH(NC), .DIV_W(DW), .RST_HOLD(HOLD0), .DEF_HALF(DEFH)) dut0 (
        .clk(clk), .rst(rst), .half_cnt(half_cnt), .load(load), .sw_rst(sw_rst), .gate(gate),
        .cd_clk(clk0), .cd_rise(rise0), .cd_reset(reset0), .cd_busy(busy0)
    );

    clkdom_gen #(.NUM_CH(NC), .DIV_W(DW), .RST_HOLD(HOLD1), .DEF_HALF(DEFH)) dut1 (
        .clk(clk), .rst(rst), .half_cnt(half_cnt), .load(load), .sw_rst(sw_rst), .gate(gate),
        .cd_clk(clk1), .cd_rise(rise1), .cd_reset(reset1), .cd_busy(busy1)
    );

    always #5 clk = ~clk;

    function automatic int holdOf(input int k);
        return (k == 0) ? HOLD0 : HOLD1;
    endfunction

    task automatic checkOutput(input string name, input logic [EW-1:0] actual,
                               input logic [EW-1:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s at %0t: got busy/reset/rise/clk=%b required=%b",
                     name, $time, actual, expected);
        end
    endtask

    // Reference model: each channel counts down the clk cycles left in the current phase,
    // and the reset sequence is counted in falling edges of the divided clock.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            for (int k = 0; k < NI; k++) begin
                for (int c = 0; c < NC; c++) begin
                    m_clk[k][c]   = 1'b0;
                    m_rise[k][c]  = 1'b0;
                    m_rst[k][c]   = 1'b0;
                    m_pend[k][c]  = 1'b1;
                    m_stage[k][c] = 0;
                    m_hl[k][c]    = 0;
                    m_act[k][c]   = DEFH;
                    m_shd[k][c]   = DEFH;
                    m_left[k][c]  = DEFH + 1;
                    m_gated[k][c] = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                for (int c = 0; c < NC; c++) begin
                    bit fall;
                    fall = 1'b0;
                    m_rise[k][c] = 1'b0;
                    if (sw_rst[c]) m_pend[k][c] = 1'b1;
                    if (GATE_EN && m_gated[k][c]) begin
                        if (!gate[c]) begin
                            m_gated[k][c] = 1'b0;
                            m_left[k][c]  = m_act[k][c] + 1;
                        end
                    end else begin
                        m_left[k][c]--;
                        if (m_left[k][c] == 0) begin
                            m_clk[k][c] = !m_clk[k][c];
                            if (m_clk[k][c]) begin
                                m_rise[k][c] = 1'b1;
                            end else begin
                                fall = 1'b1;
                                m_act[k][c] = m_shd[k][c];
                            end
                            m_left[k][c] = m_act[k][c] + 1;
                        end
                    end
                    if (fall) begin
                        if (m_stage[k][c] == 0) begin
                            if (m_pend[k][c]) m_stage[k][c] = 1;
                        end else if (m_stage[k][c] == 1 || m_pend[k][c]) begin
                            m_rst[k][c]   = 1'b1;
                            m_hl[k][c]    = holdOf(k);
                            m_pend[k][c]  = 1'b0;
                            m_stage[k][c] = 2;
                        end else begin
                            m_hl[k][c]--;
                            if (m_hl[k][c] == 0) begin
                                m_rst[k][c]   = 1'b0;
                                m_stage[k][c] = 0;
                            end
                        end
                        if (GATE_EN) m_gated[k][c] = gate[c];
                    end
                    if (load[c]) m_shd[k][c] = int'(half_cnt[c*DW +: DW]);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < NC; c++) begin
                exp_m[k*EW + c]        = m_clk[k][c];
                exp_m[k*EW + NC + c]   = m_rise[k][c];
                exp_m[k*EW + 2*NC + c] = m_rst[k][c];
                exp_m[k*EW + 3*NC + c] = m_pend[k][c] || (m_stage[k][c] != 0);
            end
        end
        exp_q.push_back(exp_m);
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checkOutput("inst0_outputs", {busy0, reset0, rise0, clk0}, exp_w[EW-1:0]);
            checkOutput("inst1_outputs", {busy1, reset1, rise1, clk1}, exp_w[2*EW-1:EW]);
        end
    end

    task automatic setInputs(input logic [NC-1:0] ld, input logic [NC*DW-1:0] h,
                             input logic [NC-1:0] sw, input logic [NC-1:0] gt);
        load     = ld;
        half_cnt = h;
        sw_rst   = sw;
        gate     = gt;
    endtask

    task automatic applyStimulus(input logic [NC-1:0] ld, input logic [NC*DW-1:0] h,
                                 input logic [NC-1:0] sw, input logic [NC-1:0] gt);
        @(negedge clk);
        #1;
        setInputs(ld, h, sw, gt);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) applyStimulus('0, half_cnt, '0, '0);
    endtask

    // sel 0 waits for inst0 ch0 cd_clk high, sel 1 for inst1 ch1 cd_reset high
    task automatic waitFor(input int sel, input int limit, output bit ok);
        ok = 1'b0;
        for (int j = 0; j < limit && !ok; j++) begin
            @(negedge clk);
            #1;
            setInputs('0, half_cnt, '0, '0);
            ok = (sel == 0) ? bit'(clk0[0]) : bit'(reset1[1]);
        end
        if (!ok) begin
            total_cnt++;
            $display("[TB] FAIL wait_timeout sel=%0d: got no event within %0d cycles, required one", sel, limit);
        end
    endtask

    initial begin
        bit ok;
        logic [NC-1:0] gl;
        logic [NC*DW-1:0] hv;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_state_inst0", {busy0, reset0, rise0, clk0}, {{NC{1'b1}}, {(3*NC){1'b0}}});
        checkOutput("reset_state_inst1", {busy1, reset1, rise1, clk1}, {{NC{1'b1}}, {(3*NC){1'b0}}});
        rst = 1'b0;
        idle(40);

        // Retime ch0 to half=3 while its divided clock is high
        waitFor(0, 20, ok);
        setInputs(2'b01, {4'd1, 4'd3}, '0, '0);
        idle(40);

        // Restart a hold-3 sequence on inst1 ch1 while it is still holding
        applyStimulus('0, half_cnt, 2'b10, '0);
        waitFor(1, 100, ok);
        applyStimulus('0, half_cnt, 2'b10, '0);
        idle(50);

        applyStimulus(2'b11, '0, '0, '0);
        idle(30);

        // Async reset in the middle of a high phase
        applyStimulus(2'b11, {4'd1, 4'd1}, '0, '0);
        waitFor(0, 20, ok);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_inst0", {busy0, reset0, rise0, clk0}, {{NC{1'b1}}, {(3*NC){1'b0}}});
        checkOutput("async_rst_inst1", {busy1, reset1, rise1, clk1}, {{NC{1'b1}}, {(3*NC){1'b0}}});
        idle(3);
        rst = 1'b0;
        idle(40);

        for (int j = 0; j < 10; j++) applyStimulus('0, half_cnt, '0, 2'b11);
        idle(30);

        gl = '0;
        for (int j = 0; j < 1200; j++) begin
            for (int c = 0; c < NC; c++) begin
                hv[c*DW +: DW] = DW'($urandom_range(0, 5));
                if ($urandom_range(0, 29) == 0) gl[c] = ~gl[c];
            end
            applyStimulus({($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)}, hv,
                          {($urandom_range(0, 49) == 0), ($urandom_range(0, 49) == 0)}, gl);
        end
        idle(5);
        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/clkdom_gen.md
Name: clkdom_gen

Overview:
- Multi-channel clock-domain generator for TT designs that emulate slower synchronous domains (e.g. the 48 MHz PHY domain) from the single tile clock.
- Each channel produces a divided clock `cd_clk[i]`, a one-`clk` edge strobe, and a sync-reset `cd_reset[i]` with a guaranteed observable rising edge.
- Each channel's reset is held for a programmable number of domain cycles and is re-armable by software.
- Sits between the tile top and domain-owning cores; channels are loaded from a wishbone-facing register block.

Parameters:
- NUM_CH, 2, number of independent clock-domain channels.
- DIV_W, 4, width of each half-period count field.
- RST_HOLD, 1, number of `cd_clk` periods `cd_reset` stays high after assertion (1..15).
- DEF_HALF, 1, reset value of every channel's half-period count (1 gives clk/4).

Ports:
- clk, input, 1, tile clock.
- rst, input, 1, reset; asynchronous, active-high.
- half_cnt, input, NUM_CH*DIV_W, per-channel half-period count; channel i uses bits `[i*DIV_W +: DIV_W]`.
- load, input, NUM_CH, per-channel strobe; captures `half_cnt` slice into a shadow register.
- sw_rst, input, NUM_CH, per-channel pulse; restarts that channel's reset sequence.
- gate, input, NUM_CH, per-channel clock-stop request (see Optional Feature).
- cd_clk, output, NUM_CH, divided clocks.
- cd_rise, output, NUM_CH, one-`clk` pulse in the cycle `cd_clk[i]` goes 0→1.
- cd_reset, output, NUM_CH, domain sync-reset, changes only on `cd_clk` falling edges.
- cd_busy, output, NUM_CH, high while a reset sequence is pending or active.

Behaviour:
- Reset state (async `rst`), per channel:
  - `cd_clk`=0, `cd_rise`=0, `cd_reset`=0, pending=1, `cd_busy`=1.
  - Counter=0, active half = shadow half = DEF_HALF, hold counter=0.
- Divider:
  - Counter increments each `clk`.
  - When counter == active half, the counter clears and `cd_clk` toggles.
  - Period is 2*(half+1) `clk` cycles; half=0 gives clk/2.
  - Counter width is DIV_W and never wraps past the active half.
- Ratio update:
  - `load[i]` writes the shadow register; the last load before transfer wins.
  - Shadow→active transfer happens only at the terminal count that produces a falling edge (`cd_clk` 1→0). The high phase is therefore never truncated.
  - A load arriving in the same cycle as a falling edge is applied at the next falling edge.
- Edge strobe: `cd_rise[i]` is asserted in the same `clk` cycle that the `cd_clk` register goes 1.
- Reset FSM per channel, evaluated only at falling-edge terminal counts:
  - IDLE: `cd_reset`=0. If pending, go to ASSERT.
  - ASSERT: `cd_reset`←1, hold counter←RST_HOLD-1, pending←0, go to HOLD.
  - HOLD: if hold counter==0, `cd_reset`←0 and go to IDLE; else decrement.
  - After `rst` release, `cd_clk` therefore completes at least one full low+high period with `cd_reset`=0 before `cd_reset` rises.
- `sw_rst[i]`:
  - Sets pending in the cycle it is seen, from any state.
  - If received in HOLD, the sequence restarts at the next falling edge: ASSERT reloads the hold counter and `cd_reset` stays high continuously.
  - `sw_rst` in the same cycle as an FSM-evaluating falling edge is acted on at that edge.
- `cd_busy` = pending | (state != IDLE).
- `rst` mid-operation forces the reset state immediately, including mid high phase: `cd_clk` drops to 0 asynchronously.
- Channels are fully independent; no shared counters.

Optional Feature:
- Macro: CLKDOM_GEN_GATE_EN.
- Defined:
  - `gate[i]` high, sampled at a falling-edge terminal count, holds that channel's counter at 0 with `cd_clk` low. No rising edge is produced.
  - Deassertion resumes with a full low phase: the first rise comes half+1 cycles after the `gate` drop is seen.
  - The reset FSM is frozen while gated; pending is still latched.
  - `cd_busy` is unaffected by `gate`.
- Undefined: `gate` is ignored and the channel runs freely.

Test Plan:
- `rst` release with DEF_HALF=1, RST_HOLD=1 → `cd_clk` toggles every 2 `clk`. `cd_reset` rises at the 2nd `cd_clk` falling edge, falls at the 3rd; `cd_busy` clears with it.
- load half=3 mid high phase on ch0 → current high phase still 2 cycles; from the next falling edge, 4-cycle phases. ch1 is unchanged.
- RST_HOLD=3, `sw_rst` pulsed during HOLD → `cd_reset` stays high continuously, then falls 3 `cd_clk` periods after the restart edge.
- half=0 → `cd_clk` period 2 `clk`; `cd_rise` asserts every other cycle coincident with `cd_clk` going 1.
- Async `rst` asserted while `cd_clk`=1 → `cd_clk`, `cd_reset` and `cd_rise` go 0 without waiting for `clk`. Re-release repeats the first scenario's timing.
- With CLKDOM_GEN_GATE_EN, `gate` held 10 cycles → `cd_clk` low throughout, no `cd_rise`. First rise occurs half+1 cycles after `gate` drops. Without the macro the same stimulus leaves `cd_clk` toggling.
